// File: rtl/mem_region_router_pkg.sv
// Shared types and defaults for the CPU-to-peripheral region router.
// FSM state encodings are fixed so the bus analyser decodes them consistently.
package mem_region_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam int DEFAULT_ADDR_W    = 27;
  localparam int DEFAULT_DATA_W    = 32;
  localparam int DEFAULT_N_REGIONS = 8;
  localparam int DEFAULT_TIMEOUT   = 1023;

  // A zero timeout still needs a legal one-bit counter.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_region_router_if.sv
// CPU-side request/reply bus of the region router.
// The CPU drives the master modport; the router consumes the slave modport.
interface mem_region_router_if
  import mem_region_router_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              we;
  logic              start;
  logic              busy;
  logic [DATA_W-1:0] q;
  logic              err;

  modport master (output address, data, we, start, input busy, q, err);
  modport slave  (input address, data, we, start, output busy, q, err);
endinterface

// File: rtl/mem_region_router_addr_region_decoder.sv
// Combinational address decode: one-hot region hit, miss flag and region-relative offset.
// Overlapping regions resolve to the lowest index.
module addr_region_decoder
  import mem_region_router_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int N_REGIONS = DEFAULT_N_REGIONS,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_END  = '0
) (
  input  logic [ADDR_W-1:0]    address,
  output logic [N_REGIONS-1:0] hit,
  output logic                 miss,
  output logic [ADDR_W-1:0]    offset
);
  logic [N_REGIONS-1:0] raw_hit;
  logic [ADDR_W-1:0]    base_arr [N_REGIONS];
  logic                 found;

  generate
    for (genvar gi = 0; gi < N_REGIONS; gi++) begin : g_region
      assign base_arr[gi] = REGION_BASE[gi*ADDR_W +: ADDR_W];
      assign raw_hit[gi]  = (address >= REGION_BASE[gi*ADDR_W +: ADDR_W]) &&
                            (address <  REGION_END[gi*ADDR_W +: ADDR_W]);
    end
  endgenerate

  always_comb begin
    hit    = '0;
    offset = '0;
    found  = 1'b0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (raw_hit[i] && !found) begin
        hit[i] = 1'b1;
        offset = address - base_arr[i];
        found  = 1'b1;
      end
    end
  end

  assign miss = ~|raw_hit;

endmodule

// File: rtl/mem_region_router.sv
// Routes one CPU request at a time to the decoded slave region, waits for its ack
// (or a timeout) and returns read data plus an error flag.
module mem_region_router
  import mem_region_router_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int N_REGIONS = DEFAULT_N_REGIONS,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_END  = '0,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        reset,
  mem_region_router_if.slave          cpu,
  output logic [N_REGIONS-1:0]        s_sel,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_d,
  output logic                        s_we,
  output logic [N_REGIONS-1:0]        s_start,
  input  logic [N_REGIONS-1:0]        s_ack,
  input  logic [N_REGIONS*DATA_W-1:0] s_q
);
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e               state_q, state_d;
  logic                 armed_q, armed_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 we_q, we_d;
  logic [DATA_W-1:0]    q_q, q_d;
  logic [DATA_W-1:0]    s_d_q, s_d_d;
  logic [ADDR_W-1:0]    s_addr_q, s_addr_d;
  logic [N_REGIONS-1:0] sel_q, sel_d;
  logic [N_REGIONS-1:0] s_start_q, s_start_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [N_REGIONS-1:0] dec_hit;
  logic                 dec_miss;
  logic [ADDR_W-1:0]    dec_offset;
  logic [DATA_W-1:0]    rd_masked [N_REGIONS];
  logic [DATA_W-1:0]    rd_data;
  logic                 ack_sel;
  logic [CNT_W-1:0]     count_inc;

  addr_region_decoder #(
    .ADDR_W      (ADDR_W),
    .N_REGIONS   (N_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_END  (REGION_END)
  ) u_decoder (
    .address (cpu.address),
    .hit     (dec_hit),
    .miss    (dec_miss),
    .offset  (dec_offset)
  );

  generate
    for (genvar gi = 0; gi < N_REGIONS; gi++) begin : g_rdmux
      assign rd_masked[gi] = sel_q[gi] ? s_q[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      rd_data = rd_data | rd_masked[i];
    end
  end

  // Only the selected region's ack counts; the counter saturates instead of wrapping.
  assign ack_sel   = |(s_ack & sel_q);
  assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    busy_d    = busy_q;
    err_d     = err_q;
    we_d      = we_q;
    q_d       = q_q;
    s_d_d     = s_d_q;
    s_addr_d  = s_addr_q;
    sel_d     = sel_q;
    s_start_d = '0;
    count_d   = count_q;
    case (state_q)
      ST_IDLE: begin
        if (!cpu.start) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          if (!dec_miss) begin
            sel_d     = dec_hit;
            s_addr_d  = dec_offset;
            s_d_d     = cpu.data;
            we_d      = cpu.we;
            s_start_d = dec_hit;
            busy_d    = 1'b1;
            err_d     = 1'b0;
            count_d   = '0;
            state_d   = ST_ISSUE;
          end else begin
            q_d     = '0;
            err_d   = 1'b1;
            state_d = ST_RELEASE;
          end
        end
      end
      ST_ISSUE, ST_WAIT: begin
        if (ack_sel) begin
          busy_d  = 1'b0;
          q_d     = we_q ? '0 : rd_data;
          err_d   = 1'b0;
          sel_d   = '0;
          state_d = ST_RELEASE;
        end else if (state_q == ST_WAIT && TIMEOUT != 0 && count_q == TIMEOUT_C) begin
          busy_d  = 1'b0;
          q_d     = '0;
          err_d   = 1'b1;
          sel_d   = '0;
          state_d = ST_RELEASE;
        end else begin
          count_d = count_inc;
          state_d = ST_WAIT;
        end
      end
      ST_RELEASE: begin
        armed_d = 1'b0;
        if (!cpu.start) begin
          armed_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      armed_q   <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      q_q       <= '0;
      s_d_q     <= '0;
      s_addr_q  <= '0;
      sel_q     <= '0;
      s_start_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      we_q      <= we_d;
      q_q       <= q_d;
      s_d_q     <= s_d_d;
      s_addr_q  <= s_addr_d;
      sel_q     <= sel_d;
      s_start_q <= s_start_d;
      count_q   <= count_d;
    end
  end

  assign cpu.busy = busy_q;
  assign cpu.q    = q_q;
  assign cpu.err  = err_q;
  assign s_sel    = sel_q;
  assign s_addr   = s_addr_q;
  assign s_d      = s_d_q;
  assign s_we     = we_q & (|sel_q);
  assign s_start  = s_start_q;

endmodule

// File: tb/tb_mem_region_router.sv
// Directed bench for mem_region_router: a transaction-level model predicts every
// output each cycle; literal checks pin the key latencies and data values.
module tb_mem_region_router;
  localparam int AW = 27;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int TO = 8;
  localparam logic [NR*AW-1:0] BASES = {27'hC02622, 27'hC00000, 27'h800000, 27'h000000};
  localparam logic [NR*AW-1:0] ENDS  = {27'hC02732, 27'hC02622, 27'hC00000, 27'h800000};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_region_router_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_if ();

  logic [NR-1:0]    s_sel, s_start, s_ack;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_d;
  logic             s_we;
  logic [NR*DW-1:0] s_q;

  mem_region_router #(
    .ADDR_W (AW), .DATA_W (DW), .N_REGIONS (NR),
    .REGION_BASE (BASES), .REGION_END (ENDS), .TIMEOUT (TO)
  ) dut (
    .clk (clk), .reset (reset), .cpu (cpu_if.slave),
    .s_sel (s_sel), .s_addr (s_addr), .s_d (s_d), .s_we (s_we),
    .s_start (s_start), .s_ack (s_ack), .s_q (s_q)
  );

  logic [AW-1:0] base_t [NR];
  logic [AW-1:0] end_t  [NR];

  // Per-cycle expectations and the model's persistent reply state
  logic          exp_busy, exp_err, exp_swe;
  logic [DW-1:0] exp_q, exp_sd;
  logic [NR-1:0] exp_sel, exp_start;
  logic [AW-1:0] exp_saddr;
  logic [DW-1:0] mdl_q, mdl_sd;
  logic          mdl_err;
  logic [AW-1:0] mdl_saddr;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int i = 0; i < NR; i++) begin
      if (a >= base_t[i] && a < end_t[i]) return i;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",    cpu_if.busy, exp_busy);
      chk("q",       cpu_if.q,    exp_q);
      chk("err",     cpu_if.err,  exp_err);
      chk("s_sel",   s_sel,       exp_sel);
      chk("s_start", s_start,     exp_start);
      chk("s_addr",  s_addr,      exp_saddr);
      chk("s_d",     s_d,         exp_sd);
      chk("s_we",    s_we,        exp_swe);
    end
  end

  task automatic set_reset_exp();
    mdl_q = '0; mdl_err = 1'b0; mdl_saddr = '0; mdl_sd = '0;
    exp_busy = 1'b0; exp_err = 1'b0; exp_swe = 1'b0; exp_q = '0;
    exp_sd = '0; exp_sel = '0; exp_start = '0; exp_saddr = '0;
  endtask

  // d = edges after accept at which the selected region acks (1 = during ISSUE);
  // hold = extra cycles start stays high after the reply; rst_at = reset after that many edges.
  task automatic run_txn(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic wr, input int d, input logic [DW-1:0] rdata,
                         input logic [NR-1:0] extra, input int hold, input int rst_at,
                         input int exp_busy_cyc);
    int r, rep, busy_cnt, pulse_cnt;
    logic [NR-1:0] oh;
    logic [AW-1:0] off;
    logic          res_err;
    logic [DW-1:0] res_q;
    r = decode(addr);
    oh = '0; off = '0;
    if (r < 0) begin
      rep = 0; res_err = 1'b1; res_q = '0;
    end else begin
      oh[r] = 1'b1;
      off = addr - base_t[r];
      if (d <= TO + 1) begin
        rep = d; res_err = 1'b0; res_q = wr ? '0 : rdata;
      end else begin
        rep = TO + 1; res_err = 1'b1; res_q = '0;
      end
    end
    for (int i = 0; i < NR; i++) s_q[i*DW +: DW] = (i == r) ? rdata : (32'hA5A50000 | i);
    cpu_if.address = addr; cpu_if.data = wdata; cpu_if.we = wr; cpu_if.start = 1'b1;
    s_ack = extra;
    @(posedge clk); #2;
    busy_cnt = 0; pulse_cnt = 0;
    for (int k = 0; k <= rep + hold; k++) begin
      if (k == 0 && r >= 0) begin mdl_saddr = off; mdl_sd = wdata; end
      if (k >= rep) begin
        mdl_q = res_q; mdl_err = res_err;
        exp_busy = 1'b0; exp_sel = '0; exp_start = '0; exp_swe = 1'b0;
      end else begin
        exp_busy = 1'b1; exp_sel = oh; exp_start = (k == 0) ? oh : '0; exp_swe = wr;
      end
      exp_q = mdl_q; exp_err = (k >= rep) ? mdl_err : 1'b0;
      exp_saddr = mdl_saddr; exp_sd = mdl_sd;
      if (cpu_if.busy) busy_cnt++;
      if (|s_start) pulse_cnt++;
      if (k == 0) begin
        cpu_if.address = ~addr; cpu_if.data = ~wdata; cpu_if.we = ~wr;
      end
      s_ack = extra | ((r >= 0 && k == d - 1) ? oh : '0);
      if (k == rst_at) begin
        reset = 1'b1; cpu_if.start = 1'b0; s_ack = '0;
        @(posedge clk); #2;
        reset = 1'b0;
        set_reset_exp();
        chk({tag, "_busy_after_reset"}, cpu_if.busy, 1'b0);
        chk({tag, "_sel_after_reset"}, s_sel, 4'b0000);
        s_ack = oh;
        @(posedge clk); #2;
        @(posedge clk); #2;
        s_ack = '0;
        chk({tag, "_late_ack_ignored"}, cpu_if.busy, 1'b0);
        return;
      end
      if (k >= rep + hold) cpu_if.start = 1'b0;
      @(posedge clk); #2;
    end
    chk({tag, "_busy_cycles"}, busy_cnt, exp_busy_cyc);
    chk({tag, "_start_pulses"}, pulse_cnt, (r >= 0) ? 1 : 0);
  endtask

  initial begin
    base_t = '{27'h000000, 27'h800000, 27'hC00000, 27'hC02622};
    end_t  = '{27'h800000, 27'hC00000, 27'hC02622, 27'hC02732};
    reset = 1'b1;
    cpu_if.address = '0; cpu_if.data = '0; cpu_if.we = 1'b0; cpu_if.start = 1'b0;
    s_ack = '0; s_q = '0;
    set_reset_exp();
    @(posedge clk); #2;
    chk_en = 1'b1;
    chk("reset_busy", cpu_if.busy, 1'b0);
    chk("reset_err", cpu_if.err, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;

    run_txn("t1_rd_r1", 27'h800010, 32'h0, 1'b0, 1, 32'hDEADBEEF, 4'b0000, 0, -1, 1);
    chk("t1_q", cpu_if.q, 32'hDEADBEEF);
    chk("t1_s_addr", s_addr, 27'h10);
    chk("t1_err", cpu_if.err, 1'b0);

    run_txn("t2_wr_r2", 27'hC00005, 32'h55, 1'b1, 4, 32'h13579BDF, 4'b0000, 0, -1, 4);
    chk("t2_q", cpu_if.q, 32'h0);
    chk("t2_s_d", s_d, 32'h55);

    run_txn("t3_miss", 27'hC10000, 32'h0, 1'b0, 1, 32'h11111111, 4'b0000, 0, -1, 0);
    chk("t3_err", cpu_if.err, 1'b1);
    chk("t3_q", cpu_if.q, 32'h0);

    run_txn("t4_tmo_r0", 27'h000100, 32'h0, 1'b0, 100, 32'h22222222, 4'b1000, 0, -1, 9);
    chk("t4_err", cpu_if.err, 1'b1);

    run_txn("t5_hold_r3", 27'hC02700, 32'h0, 1'b0, 2, 32'h12345678, 4'b0000, 5, -1, 2);
    chk("t5_q", cpu_if.q, 32'h12345678);
    chk("t5_s_addr", s_addr, 27'hDE);

    run_txn("t6_ackwin_r2", 27'hC02621, 32'h0, 1'b0, 9, 32'hCAFEF00D, 4'b0000, 0, -1, 9);
    chk("t6_err", cpu_if.err, 1'b0);
    chk("t6_q", cpu_if.q, 32'hCAFEF00D);

    run_txn("t7_wr_r3_base", 27'hC02622, 32'hA, 1'b1, 3, 32'h33333333, 4'b0000, 0, -1, 3);
    chk("t7_s_addr", s_addr, 27'h0);

    run_txn("t8_end_miss", 27'hC02732, 32'h0, 1'b0, 1, 32'h44444444, 4'b0000, 0, -1, 0);
    run_txn("t9_r0_top_tmo", 27'h7FFFFF, 32'h0, 1'b0, 10, 32'h55555555, 4'b0000, 0, -1, 9);
    chk("t9_s_addr", s_addr, 27'h7FFFFF);

    run_txn("t10_rst_wait", 27'hC00100, 32'h0, 1'b0, 100, 32'h66666666, 4'b0000, 0, 3, 0);
    run_txn("t11_after_rst", 27'h800000, 32'h0, 1'b0, 2, 32'h77777777, 4'b0000, 0, -1, 2);
    chk("t11_q", cpu_if.q, 32'h77777777);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
